// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one RAM port between the instruction-fetch requester and the
// load/store requester. One request is accepted at a time through a
// valid/ready handshake. When both requesters are valid, round-robin
// arbitration picks the winner. The accepted access is held on the RAM for
// WAIT_CYCLES cycles, and the winner then receives a one-cycle response pulse.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   if_req_valid_i/if_req_ready_o  fetch request handshake (accepted in IDLE only)
//   if_addr_i                      fetch byte address (always a 4-byte read)
//   if_resp_valid_o/if_resp_data_o fetch response pulse and fetched word
//   ls_req_valid_i/ls_req_ready_o  load/store request handshake
//   ls_w_rn_i, ls_width_i          1 = store / 0 = load, width 00 b, 01 h, 10 w
//   ls_data_i, ls_addr_i           store data, byte address
//   ls_resp_valid_o/ls_resp_data_o load/store response (store ack, data 0)
//   ram_w_rn_o, ram_width_o        RAM write enable and access width
//   ram_data_o, ram_addr_o         RAM write data and address
//   ram_data_i                     RAM combinational read data
module mem_arbiter #(
  parameter int XLEN        = 32,
  parameter int RAM_WIDTH   = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_req_valid_i,
  output logic                 if_req_ready_o,
  input  logic [RAM_WIDTH-1:0] if_addr_i,
  output logic                 if_resp_valid_o,
  output logic [XLEN-1:0]      if_resp_data_o,
  input  logic                 ls_req_valid_i,
  output logic                 ls_req_ready_o,
  input  logic                 ls_w_rn_i,
  input  logic [1:0]           ls_width_i,
  input  logic [XLEN-1:0]      ls_data_i,
  input  logic [RAM_WIDTH-1:0] ls_addr_i,
  output logic                 ls_resp_valid_o,
  output logic [XLEN-1:0]      ls_resp_data_o,
  output logic                 ram_w_rn_o,
  output logic [1:0]           ram_width_o,
  output logic [XLEN-1:0]      ram_data_o,
  output logic [RAM_WIDTH-1:0] ram_addr_o,
  input  logic [XLEN-1:0]      ram_data_i
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic       OWNER_IF = 1'b0;
  localparam logic       OWNER_LS = 1'b1;
  localparam logic [1:0] WIDTH_WORD = 2'b10;
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t                 state_r;
  state_t                 state_s;
  logic [3:0]             cnt_r;
  logic                   last_grant_r;
  logic                   owner_r;
  logic                   w_rn_r;
  logic [1:0]             width_r;
  logic [XLEN-1:0]        data_r;
  logic [RAM_WIDTH-1:0]   addr_r;
  logic                   if_resp_valid_r;
  logic                   ls_resp_valid_r;
  logic [XLEN-1:0]        if_resp_data_r;
  logic [XLEN-1:0]        ls_resp_data_r;
  logic                   if_ready_s;
  logic                   ls_ready_s;
  logic                   handshake_s;
  logic                   last_access_s;

  // Grant: the requester that did not win last time wins a tie.
  // Ready is held low during reset so that no handshake is lost.
  always_comb begin
    if_ready_s = 1'b0;
    ls_ready_s = 1'b0;
    if ((state_r == ST_IDLE) && !reset) begin
      if (if_req_valid_i && ls_req_valid_i) begin
        if (last_grant_r == OWNER_LS) begin
          if_ready_s = 1'b1;
        end else begin
          ls_ready_s = 1'b1;
        end
      end else begin
        if_ready_s = if_req_valid_i;
        ls_ready_s = ls_req_valid_i;
      end
    end else begin
      if_ready_s = 1'b0;
      ls_ready_s = 1'b0;
    end
  end

  assign handshake_s   = if_ready_s | ls_ready_s;
  assign last_access_s = (state_r == ST_ACCESS) && (cnt_r == LAST_CNT);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:   state_s = handshake_s ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: state_s = last_access_s ? ST_RESP : ST_ACCESS;
      ST_RESP:   state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Request latch, wait counter, grant history and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r           <= 4'd0;
      last_grant_r    <= OWNER_LS;
      owner_r         <= OWNER_IF;
      w_rn_r          <= 1'b0;
      width_r         <= 2'b00;
      data_r          <= '0;
      addr_r          <= '0;
      if_resp_valid_r <= 1'b0;
      ls_resp_valid_r <= 1'b0;
      if_resp_data_r  <= '0;
      ls_resp_data_r  <= '0;
    end else begin
      // Response pulses are produced only by the final ACCESS cycle.
      if_resp_valid_r <= last_access_s && (owner_r == OWNER_IF);
      ls_resp_valid_r <= last_access_s && (owner_r == OWNER_LS);
      if (handshake_s) begin
        owner_r      <= ls_ready_s ? OWNER_LS : OWNER_IF;
        last_grant_r <= ls_ready_s ? OWNER_LS : OWNER_IF;
        w_rn_r       <= ls_ready_s ? ls_w_rn_i : 1'b0;
        width_r      <= ls_ready_s ? ls_width_i : WIDTH_WORD;
        data_r       <= ls_ready_s ? ls_data_i : '0;
        addr_r       <= ls_ready_s ? ls_addr_i : if_addr_i;
        cnt_r        <= 4'd0;
      end else if (last_access_s) begin
        if (owner_r == OWNER_IF) begin
          if_resp_data_r <= ram_data_i;
        end else begin
          ls_resp_data_r <= w_rn_r ? '0 : ram_data_i;
        end
      end else if (state_r == ST_ACCESS) begin
        cnt_r <= cnt_r + 4'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // RAM drive: latched request during ACCESS, with the write enable only in
  // its final cycle. Reset gates the write so an interrupted store never lands.
  always_comb begin
    ram_w_rn_o  = 1'b0;
    ram_width_o = WIDTH_WORD;
    ram_data_o  = '0;
    ram_addr_o  = '0;
    if (state_r == ST_ACCESS) begin
      ram_w_rn_o  = w_rn_r && last_access_s && !reset;
      ram_width_o = width_r;
      ram_data_o  = data_r;
      ram_addr_o  = addr_r;
    end else begin
      ram_w_rn_o  = 1'b0;
      ram_width_o = WIDTH_WORD;
      ram_data_o  = '0;
      ram_addr_o  = '0;
    end
  end

  assign if_req_ready_o  = if_ready_s;
  assign ls_req_ready_o  = ls_ready_s;
  // A pulse already registered for RESP is suppressed if reset lands on it.
  assign if_resp_valid_o = if_resp_valid_r & ~reset;
  assign ls_resp_valid_o = ls_resp_valid_r & ~reset;
  assign if_resp_data_o  = if_resp_data_r;
  assign ls_resp_data_o  = ls_resp_data_r;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single simulation RAM port between the instruction-fetch requester and the load/store requester.
- Accepts one request at a time using a valid/ready handshake and picks a winner by round-robin.
- Sequences the RAM access over a configurable number of wait cycles.
- Returns a one-cycle response pulse to the winning requester.
- Sits between the core's fetch and LSU units and the ram block in the test harness.

Parameters:
- XLEN, 32, data width; taken from imhotep_pkg.
- RAM_WIDTH, imhotep_pkg value, RAM address width.
- WAIT_CYCLES, 1, number of cycles the ACCESS state lasts; legal range 1..15.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- if_req_valid_i  in  1  fetch request valid.
- if_req_ready_o  out  1  fetch request accepted this cycle.
- if_addr_i  in  RAM_WIDTH  fetch byte address. Fetch is always a 4-byte read.
- if_resp_valid_o  out  1  fetch response pulse.
- if_resp_data_o  out  XLEN  fetched word.
- ls_req_valid_i  in  1  load/store request valid.
- ls_req_ready_o  out  1  load/store request accepted this cycle.
- ls_w_rn_i  in  1  1 = store, 0 = load.
- ls_width_i  in  2  00 = byte, 01 = half, 10 = word.
- ls_data_i  in  XLEN  store data.
- ls_addr_i  in  RAM_WIDTH  load/store byte address.
- ls_resp_valid_o  out  1  load/store response pulse. Also acts as the store acknowledge.
- ls_resp_data_o  out  XLEN  load data; 0 for stores.
- ram_w_rn_o  out  1  RAM write enable.
- ram_width_o  out  2  RAM access width.
- ram_data_o  out  XLEN  RAM write data.
- ram_addr_o  out  RAM_WIDTH  RAM address.
- ram_data_i  in  XLEN  RAM combinational read data.

Behaviour:
- Reset (synchronous, while reset = 1):
  - State goes to IDLE, the wait counter clears and last_grant is set to LS, so fetch wins the first tie.
  - All response valids, response data and latched request registers clear to 0.
  - ram_w_rn_o is gated combinationally with !reset, so a reset during ACCESS never issues a write.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - if_req_ready_o / ls_req_ready_o may be 1 only in IDLE. They are combinational from the valids.
  - Only one valid: that requester gets ready = 1.
  - Both valid: the requester not in last_grant gets ready = 1; the other sees ready = 0 and must hold its request stable.
  - On handshake: latch the request (owner, w_rn, width, data, addr) and update last_grant to the owner. Clear the counter and go to ACCESS.
  - Fetch is latched as w_rn = 0, width = 10.
  - No valid: stay in IDLE.
- ACCESS:
  - Lasts exactly WAIT_CYCLES cycles.
  - ram_addr_o, ram_width_o and ram_data_o drive the latched values for the whole state.
  - ram_w_rn_o = latched w_rn only in the final ACCESS cycle (counter == WAIT_CYCLES-1); otherwise 0. Exactly one write per store.
  - In the final cycle: capture ram_data_i into the owner's response data register (0 for stores), then go to RESP.
- RESP:
  - The owner's resp_valid is 1 for exactly one cycle, with data stable during it. The non-owner's resp_valid stays 0.
  - There is no back-pressure: requesters must sink the response.
  - Next state is IDLE.
- Outside ACCESS the RAM outputs are: ram_w_rn_o = 0, ram_addr_o = 0, ram_width_o = 10, ram_data_o = 0.
- Latency and throughput:
  - A handshake in cycle T gives resp_valid in cycle T + WAIT_CYCLES + 1.
  - The next handshake is possible at T + WAIT_CYCLES + 2.
  - Maximum rate is one access per WAIT_CYCLES+2 cycles.
- Response data registers hold their value after the pulse until overwritten by the next access for the same owner.
- Width 11 is forwarded unchanged. The RAM ignores it, so the load returns 0 and a store writes nothing; a response is still produced.
- Address wrap (addr + 3 beyond the top of RAM) is passed through unmodified. Wrapping is the RAM's concern.
- A valid that drops before its handshake is simply not serviced; no state change.
- Reset mid-ACCESS or mid-RESP: the access is discarded, no response pulse is produced, and operation restarts from IDLE.

Test Plan:
- Single fetch, WAIT_CYCLES=1:
  - Preload RAM[0x10..0x13] = 0x11,0x22,0x33,0x44; assert if_req_valid with addr 0x10 in cycle 0.
  - Expect if_req_ready = 1 in cycle 0.
  - Expect if_resp_valid = 1 in cycle 2 with data 0x44332211; ls_resp_valid stays 0.
- Store then load, half width:
  - Store 0xBEEF, width 01, addr 0x20.
  - Expect ram_w_rn_o high for exactly 1 cycle and ls_resp_valid with data 0.
  - A following load (width 01, addr 0x20) returns 0x0000BEEF; RAM[0x22] is unchanged.
- Simultaneous requests held for 3 consecutive grants after reset:
  - Grant order is fetch, LS, fetch.
  - The loser's ready stays 0 until IDLE recurs; handshakes are 3 cycles apart.
- WAIT_CYCLES=3:
  - Issue a word store of 0xCAFEF00D at addr 0x40.
  - Expect ram_w_rn_o asserted only in the 3rd ACCESS cycle and ls_resp_valid at T+4.
  - A subsequent word read of 0x40 returns 0xCAFEF00D.
- Reset during the ACCESS of a store of 0xFF at addr 0x08:
  - No response pulse; ram_w_rn_o never goes to 1.
  - State returns to IDLE, and the next request is accepted immediately.
- Byte load at top address 2^RAM_WIDTH-1 after storing 0x5A there:
  - Returns 0x0000005A.
  - Arbiter addr output equals the input unchanged.
